// File: rtl/pipelined_rca_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_rca_adder
// Description : WIDTH-bit ripple-carry adder/subtractor split into STAGES
//               carry-chained slices, with valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_rca_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Slice-k inputs: operands, partial sum, carry and valid entering slice k
    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_b_in  [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];
    logic [WIDTH-1:0] w_s_nxt [STAGES];
    logic             w_c_in  [STAGES];
    logic             w_c_nxt [STAGES];
    logic             w_v_in  [STAGES];
    logic             w_en;
    logic             w_ovf_nxt;

    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    assign w_en = ~r_v[LAST] | out_ready;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            localparam logic [WIDTH-1:0] c_mask = WIDTH'({SW{1'b1}}) << (k * SW);
            logic [SW:0] w_add;

            if (k == 0) begin : g_head
                // Subtraction is a + ~b + 1, so the carry-in is forced high
                assign w_a_in[k] = a;
                assign w_b_in[k] = sub ? ~b : b;
                assign w_c_in[k] = sub | cin;
                assign w_s_in[k] = '0;
                assign w_v_in[k] = in_valid;
            end else begin : g_body
                assign w_a_in[k] = r_a[k-1];
                assign w_b_in[k] = r_b[k-1];
                assign w_c_in[k] = r_c[k-1];
                assign w_s_in[k] = r_s[k-1];
                assign w_v_in[k] = r_v[k-1];
            end

            assign w_add = {1'b0, w_a_in[k][k*SW +: SW]}
                         + {1'b0, w_b_in[k][k*SW +: SW]}
                         + {{SW{1'b0}}, w_c_in[k]};
            assign w_s_nxt[k] = (w_s_in[k] & ~c_mask) | (WIDTH'(w_add[SW-1:0]) << (k * SW));
            assign w_c_nxt[k] = w_add[SW];
        end
    endgenerate

    // Carry into the MSB is recovered from the MSB sum bit and its operands
    assign w_ovf_nxt = w_c_nxt[LAST] ^ w_a_in[LAST][WIDTH-1]
                     ^ w_b_in[LAST][WIDTH-1] ^ w_s_nxt[LAST][WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
                r_s[k] <= w_s_nxt[k];
                r_c[k] <= w_c_nxt[k];
                r_v[k] <= w_v_in[k];
            end
            r_ovf <= w_ovf_nxt;
        end
    end

    // The last stage's operand copies have no consumer
    logic w_unused_tail;
    assign w_unused_tail = ^{r_a[LAST], r_b[LAST]};

    assign in_ready  = w_en;
    assign out_valid = r_v[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_rca_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_rca_adder
// Description : Scoreboard bench for pipelined_rca_adder over five configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_rca_adder;

    localparam int NCFG = 5;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          acc;
        int          stl;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        ivld = 1'b0;
    logic        ordy = 1'b1;
    logic        cin  = 1'b0;
    logic        sub  = 1'b0;
    logic [31:0] ina  = '0;
    logic [31:0] inb  = '0;
    logic        fin  = 1'b0;
    logic        bp   = 1'b0;
    logic        win  = 1'b0;
    int          cyc  = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          run = 0, maxrun = 0, irlow = 0;

    logic [7:0]  m_sum;
    logic        m_ov, m_ir, m_co, m_ovf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    generate
        for (genvar i = 0; i < NCFG; i++) begin : g_cfg
            localparam int W = (i == 4) ? 32 : 8;
            localparam int S = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : (i == 3) ? 8 : 4;
            logic [W-1:0] s;
            logic         ov, ir, co, of;
            exp_t         q[$];
            int           stl = 0;

            pipelined_rca_adder #(.WIDTH(W), .STAGES(S)) u_dut (
                .clk(clk), .rst(rst),
                .in_valid(ivld), .in_ready(ir),
                .a(ina[W-1:0]), .b(inb[W-1:0]), .cin(cin), .sub(sub),
                .out_valid(ov), .out_ready(ordy),
                .sum(s), .cout(co), .ovf(of)
            );

            if (i == 0) begin : g_main
                assign m_sum = s;
                assign m_ov  = ov;
                assign m_ir  = ir;
                assign m_co  = co;
                assign m_ovf = of;
            end

            always @(posedge rst) q.delete();

            always @(negedge clk) begin : p_sb
                exp_t         e;
                logic [W:0]   t;
                logic [W-1:0] bb;
                if (!rst) begin
                    if (ov && ordy) begin
                        if (q.size() == 0) begin
                            chk($sformatf("cfg%0d extra_out", i), 64'(ov), 64'(0));
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("cfg%0d sum", i),  64'(s),  64'(e.s));
                            chk($sformatf("cfg%0d cout", i), 64'(co), 64'(e.co));
                            chk($sformatf("cfg%0d ovf", i),  64'(of), 64'(e.ov));
                            chk($sformatf("cfg%0d latency", i),
                                64'(cyc - e.acc - (stl - e.stl)), 64'(S));
                        end
                    end
                    if (ov && !ordy) stl++;
                    if (ivld && ir) begin
                        bb   = sub ? ~inb[W-1:0] : inb[W-1:0];
                        t    = {1'b0, ina[W-1:0]} + {1'b0, bb} + (W+1)'(sub | cin);
                        e.s  = 32'(t[W-1:0]);
                        e.co = t[W];
                        e.ov = (ina[W-1] == bb[W-1]) && (t[W-1] != ina[W-1]);
                        e.acc = cyc;
                        e.stl = stl;
                        q.push_back(e);
                    end
                end
            end

            always @(posedge fin) chk($sformatf("cfg%0d drain", i), 64'(q.size()), 64'(0));
        end
    endgenerate

    always @(negedge clk) begin
        if (win) begin
            if (m_ov) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (!m_ir) irlow++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Present one operand pair and hold it until the main instance accepts it
    task automatic send(input logic [31:0] a_, input logic [31:0] b_, input logic c_, input logic s_);
        logic ok;
        ina = a_; inb = b_; cin = c_; sub = s_; ivld = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = m_ir;
            @(posedge clk);
            #2;
            if (bp) ordy = ($urandom_range(0, 2) != 0);
        end
        if (!ok) chk("send_timeout", 64'(m_ir), 64'(1));
    endtask

    task automatic send_rand();
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] held;
        int         stale;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(m_ov),  64'(0));
        chk("rst_sum",       64'(m_sum), 64'(0));
        chk("rst_cout",      64'(m_co),  64'(0));
        chk("rst_ovf",       64'(m_ovf), 64'(0));
        chk("rst_in_ready",  64'(m_ir),  64'(1));
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Directed add / subtract / overflow vectors
        send(32'h0F, 32'h01, 1'b0, 1'b0);
        send(32'hFF, 32'h01, 1'b0, 1'b0);
        send(32'hAA, 32'h55, 1'b1, 1'b0);
        send(32'hFF, 32'hFF, 1'b1, 1'b0);
        send(32'hFF, 32'h00, 1'b1, 1'b0);
        send(32'h05, 32'h07, 1'b0, 1'b1);
        send(32'h07, 32'h07, 1'b0, 1'b1);
        send(32'h7F, 32'h01, 1'b0, 1'b0);
        send(32'h80, 32'h01, 1'b1, 1'b1);
        ivld = 1'b0;
        idle(10);

        // Back-to-back burst
        win = 1'b1;
        repeat (8) send_rand();
        ivld = 1'b0;
        idle(6);
        win = 1'b0;
        chk("burst_run",      64'(maxrun), 64'(8));
        chk("burst_in_ready", 64'(irlow),  64'(0));
        idle(6);

        // Backpressure with the main pipeline full
        ordy = 1'b0;
        send(32'h11, 32'h22, 1'b0, 1'b0);
        send(32'h33, 32'h44, 1'b1, 1'b0);
        ivld = 1'b0;
        held = m_sum;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(m_ir),  64'(0));
            chk("bp_out_valid", 64'(m_ov), 64'(1));
            chk("bp_sum_hold", 64'(m_sum), 64'(held));
        end
        @(posedge clk);
        #2;
        ordy = 1'b1;
        send(32'h55, 32'h66, 1'b0, 1'b1);
        ivld = 1'b0;
        idle(12);

        // Asynchronous reset with results in flight
        send(32'h12, 32'h34, 1'b0, 1'b0);
        send(32'h56, 32'h78, 1'b1, 1'b0);
        ivld = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(m_ov),  64'(0));
        chk("arst_sum",       64'(m_sum), 64'(0));
        chk("arst_cout",      64'(m_co),  64'(0));
        chk("arst_in_ready",  64'(m_ir),  64'(1));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_ov) stale++;
        end
        chk("arst_no_stale", 64'(stale), 64'(0));

        // Random regression, full throughput with occasional bubbles
        repeat (1000) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) begin
                ivld = 1'b0;
                idle(1);
            end
        end
        ivld = 1'b0;
        idle(12);

        // Random regression under random backpressure
        bp = 1'b1;
        repeat (300) send_rand();
        ivld = 1'b0;
        bp = 1'b0;
        ordy = 1'b1;
        idle(40);

        fin = 1'b1;
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
